mdio_register_queue: RTL
========================

# mdio_register_queue

Register-side command/response queue for the MDIO master. It sits between the host register bus and the MDIO serial engine, replacing the single-entry transmit/receive register pair with parametrised FIFOs. Clause 22 and Clause 45 frames can be queued back-to-back, and read data is buffered until the host collects it. Response space is reserved before a read is dispatched, so read data is never dropped.

## Interface
Parameters:
- CMD_DEPTH, 4: command FIFO entries; power of two, ≥2.
- RSP_DEPTH, 4: response FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high.
- transmit_data_in  input  32  MDIO frame: ST[31:30] OP[29:28] PHYAD[27:23] REGAD[22:18] TA[17:16] DATA[15:0].
- transmit_we  input  1  push transmit_data_in into the command FIFO.
- transmit_ready  output  1  command FIFO not full.
- receive_data  output  16  head of the response FIFO (show-ahead).
- receive_valid  output  1  response FIFO not empty.
- receive_re  input  1  pop the response FIFO.
- busy  output  1  command FIFO non-empty, or FSM not in IDLE.
- cmd_level  output  $clog2(CMD_DEPTH)+1  command FIFO occupancy.
- rsp_level  output  $clog2(RSP_DEPTH)+1  response FIFO occupancy.
- eng_frame  output  32  frame presented to the engine.
- eng_valid  output  1  eng_frame valid.
- eng_ready  input  1  engine accepts the frame when eng_valid && eng_ready.
- eng_done  input  1  one-cycle pulse at the end of any frame.
- eng_rdata  input  16  read data; sampled only with eng_done on a read frame.
- error  output  1  sticky error flag (see Configuration).

## Operation
- Read frame classification:
  - ST=01 and OP=10 (Clause 22 read).
  - ST=00 and OP[1]=1 (Clause 45 read / post-read-increment).
  - All other frames are writes or addresses and produce no response.
- Command push:
  - transmit_we && transmit_ready writes the frame at the tail.
  - transmit_we while full is dropped and the FIFO is unchanged.
- Response pop:
  - receive_re && receive_valid advances the head.
  - receive_re while empty has no effect.
- Reservation: `pending` is 1 while a dispatched read is awaiting eng_done, else 0. A read may be dispatched only if rsp_level + pending < RSP_DEPTH. A pop in the same cycle does not count toward this check.
- FSM states:
  - IDLE: when the command FIFO is non-empty and the head is not a blocked read, pop the head, register it into eng_frame, assert eng_valid, and go to ISSUE. A blocked read stalls the whole queue (strict order). busy stays high while stalled.
  - ISSUE: eng_valid held high and eng_frame stable until eng_ready. On eng_valid && eng_ready, deassert eng_valid and go to WAIT.
  - WAIT: on eng_done, if the frame was a read, push eng_rdata into the response FIFO; then go to IDLE.
- eng_done seen in IDLE or ISSUE is ignored.
- A response push and a host pop in the same cycle both take effect; rsp_level is unchanged. Reservation guarantees the push never meets a full FIFO.
- FIFO pointers carry one extra wrap bit. Full = MSBs differ and the rest are equal. Pointers wrap modulo 2×DEPTH.

## Timing
- Reset values: transmit_ready=1, receive_valid=0, receive_data=0, busy=0, cmd_level=0, rsp_level=0, eng_valid=0, eng_frame=0, error=0, FSM=IDLE.
- Reset mid-operation flushes both FIFOs, clears pending and drops eng_valid on the next edge. Any frame in flight is abandoned.
- Push-to-dispatch: a push at edge N into an empty FIFO with the FSM in IDLE gives eng_valid=1 in cycle N+2.
- eng_done in cycle M gives receive_valid=1 and rsp_level incremented in cycle M+1.
- Back-to-back dispatch: after eng_done at cycle M, the next eng_valid rises in cycle M+2.
- Levels and flags are registered and update the cycle after the triggering edge.

## Configuration
- MDIO_REG_ERROR_EN defined:
  - error is set by transmit_we while full, or by receive_re while empty.
  - error is cleared only by reset.
- MDIO_REG_ERROR_EN undefined:
  - error is tied to 0 and no error logic is built.
  - Dropped writes and empty pops remain silent no-ops.

## Test plan
- Reset, then one Clause 22 read push 0x6000_0000 → eng_valid in cycle +2 with eng_frame=0x6000_0000. Engine returns eng_rdata=0xBEEF → receive_valid=1 with receive_data=0xBEEF the next cycle; pop → rsp_level=0, busy=0.
- Push CMD_DEPTH+1 write frames with eng_ready=0 → transmit_ready=0 after CMD_DEPTH pushes, the extra write is dropped, and cmd_level=CMD_DEPTH. With MDIO_REG_ERROR_EN, error=1.
- RSP_DEPTH+1 Clause 45 reads (ST=00, OP=11) with no host pops → the last read stays queued with eng_valid=0 and busy=1. A single receive_re → that read dispatches within 2 cycles.
- Mixed queue of write, read, write, read → the engine sees the frames in push order, and exactly 2 responses arrive in order.
- Assert reset in WAIT with 2 queued commands and 1 response held → all levels are 0 and eng_valid=0 next cycle. A stray eng_done afterwards leaves rsp_level=0.
- Response push coinciding with receive_re at rsp_level=2 → rsp_level stays 2 and the data order is preserved.

Source files
------------

// File: rtl/mdio_register_queue.sv
// mdio_register_queue
//   Register-side command/response queue for the MDIO master. Host frames are
//   queued in a command FIFO and handed to the serial engine one at a time.
//   Read data returned by the engine is buffered in a response FIFO until the
//   host collects it. Response space is reserved before a read is dispatched,
//   so the response FIFO can never overflow.
//
//   Optional feature macro: MDIO_REG_ERROR_EN
//     defined   -> sticky error flag set by a push while full or a pop while empty
//     undefined -> error tied low, no error logic built
//
//   Ports
//     clk, reset          single clock, synchronous active-high reset
//     transmit_data_in/we host frame push; transmit_ready = command FIFO not full
//     receive_data/valid  show-ahead head of the response FIFO; receive_re pops
//     busy                command FIFO non-empty or a frame in progress
//     cmd_level/rsp_level FIFO occupancies
//     eng_frame/valid     frame offered to the engine, taken on eng_ready
//     eng_done/eng_rdata  end-of-frame pulse and read data from the engine
//     error               sticky error flag
//
//   state  | meaning
//   IDLE   | waiting for a dispatchable command at the FIFO head
//   ISSUE  | eng_valid high, waiting for eng_ready
//   WAIT   | frame accepted, waiting for eng_done
module mdio_register_queue #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  transmit_data_in,
    input  logic                         transmit_we,
    output logic                         transmit_ready,
    output logic [15:0]                  receive_data,
    output logic                         receive_valid,
    input  logic                         receive_re,
    output logic                         busy,
    output logic [$clog2(CMD_DEPTH):0]   cmd_level,
    output logic [$clog2(RSP_DEPTH):0]   rsp_level,
    output logic [31:0]                  eng_frame,
    output logic                         eng_valid,
    input  logic                         eng_ready,
    input  logic                         eng_done,
    input  logic [15:0]                  eng_rdata,
    output logic                         error
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    typedef logic [RAW+1:0] rsum_t;

    localparam logic [CAW:0] CPTR_ONE = 1;
    localparam logic [RAW:0] RPTR_ONE = 1;
    localparam rsum_t        RSP_LIM  = rsum_t'(RSP_DEPTH);

    state_t         state_q, state_d;
    logic [31:0]    cmd_mem_q [CMD_DEPTH];
    logic [31:0]    cmd_mem_d [CMD_DEPTH];
    logic [15:0]    rsp_mem_q [RSP_DEPTH];
    logic [15:0]    rsp_mem_d [RSP_DEPTH];
    logic [CAW:0]   cmd_wr_ptr_q, cmd_wr_ptr_d, cmd_rd_ptr_q, cmd_rd_ptr_d;
    logic [RAW:0]   rsp_wr_ptr_q, rsp_wr_ptr_d, rsp_rd_ptr_q, rsp_rd_ptr_d;
    logic [31:0]    eng_frame_q, eng_frame_d;
    logic           eng_valid_q, eng_valid_d;
    logic           pending_q, pending_d;

    logic           cmd_empty, cmd_full, cmd_push, cmd_pop;
    logic           rsp_empty, rsp_push, rsp_pop, rsp_room;
    logic [31:0]    cmd_head;
    logic           head_is_read;

    // Clause 22 read, or Clause 45 read / post-read-increment
    function automatic logic is_read_frame(input logic [31:0] f);
        return ((f[31:30] == 2'b01) && (f[29:28] == 2'b10)) ||
               ((f[31:30] == 2'b00) && f[29]);
    endfunction

    always_comb begin
        cmd_empty    = (cmd_wr_ptr_q == cmd_rd_ptr_q);
        cmd_full     = (cmd_wr_ptr_q[CAW] != cmd_rd_ptr_q[CAW]) &&
                       (cmd_wr_ptr_q[CAW-1:0] == cmd_rd_ptr_q[CAW-1:0]);
        rsp_empty    = (rsp_wr_ptr_q == rsp_rd_ptr_q);
        cmd_level    = cmd_wr_ptr_q - cmd_rd_ptr_q;
        rsp_level    = rsp_wr_ptr_q - rsp_rd_ptr_q;
        cmd_push     = transmit_we && !cmd_full;
        rsp_pop      = receive_re && !rsp_empty;
        cmd_head     = cmd_mem_q[cmd_rd_ptr_q[CAW-1:0]];
        head_is_read = is_read_frame(cmd_head);
        // Uses the registered level only: a host pop this cycle does not free space yet
        rsp_room     = (rsum_t'(rsp_level) + rsum_t'(pending_q)) < RSP_LIM;
    end

    always_comb begin
        state_d     = state_q;
        eng_frame_d = eng_frame_q;
        eng_valid_d = eng_valid_q;
        pending_d   = pending_q;
        cmd_pop     = 1'b0;
        rsp_push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A read without response room blocks the head, keeping strict order
                if (!cmd_empty && (!head_is_read || rsp_room)) begin
                    cmd_pop     = 1'b1;
                    eng_frame_d = cmd_head;
                    eng_valid_d = 1'b1;
                    pending_d   = head_is_read;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (eng_ready) begin
                    eng_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_done) begin
                    rsp_push  = pending_q;
                    pending_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_mem_d = cmd_mem_q;
        if (cmd_push) cmd_mem_d[cmd_wr_ptr_q[CAW-1:0]] = transmit_data_in;
        cmd_wr_ptr_d = cmd_push ? cmd_wr_ptr_q + CPTR_ONE : cmd_wr_ptr_q;
        cmd_rd_ptr_d = cmd_pop  ? cmd_rd_ptr_q + CPTR_ONE : cmd_rd_ptr_q;

        rsp_mem_d = rsp_mem_q;
        if (rsp_push) rsp_mem_d[rsp_wr_ptr_q[RAW-1:0]] = eng_rdata;
        rsp_wr_ptr_d = rsp_push ? rsp_wr_ptr_q + RPTR_ONE : rsp_wr_ptr_q;
        rsp_rd_ptr_d = rsp_pop  ? rsp_rd_ptr_q + RPTR_ONE : rsp_rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cmd_wr_ptr_q <= '0;
            cmd_rd_ptr_q <= '0;
            rsp_wr_ptr_q <= '0;
            rsp_rd_ptr_q <= '0;
            eng_frame_q  <= '0;
            eng_valid_q  <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_wr_ptr_q <= cmd_wr_ptr_d;
            cmd_rd_ptr_q <= cmd_rd_ptr_d;
            rsp_wr_ptr_q <= rsp_wr_ptr_d;
            rsp_rd_ptr_q <= rsp_rd_ptr_d;
            eng_frame_q  <= eng_frame_d;
            eng_valid_q  <= eng_valid_d;
            pending_q    <= pending_d;
        end
    end

    // Storage needs no reset; occupancy is defined by the pointers alone
    always_ff @(posedge clk) begin
        cmd_mem_q <= cmd_mem_d;
        rsp_mem_q <= rsp_mem_d;
    end

    assign transmit_ready = !cmd_full;
    assign receive_valid  = !rsp_empty;
    assign receive_data   = rsp_empty ? 16'h0000 : rsp_mem_q[rsp_rd_ptr_q[RAW-1:0]];
    assign busy           = !cmd_empty || (state_q != S_IDLE);
    assign eng_frame      = eng_frame_q;
    assign eng_valid      = eng_valid_q;

`ifdef MDIO_REG_ERROR_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q | (transmit_we && cmd_full) | (receive_re && rsp_empty);
    end

    always_ff @(posedge clk) begin
        if (reset) error_q <= 1'b0;
        else       error_q <= error_d;
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule
